// File: rtl/gemv_simd_mul_pipe.sv
// gemv_simd_mul_pipe: LANES-wide NUM_STAGE-deep valid/ready multiply / multiply-accumulate (din0 x din1 per lane -> dout products or dot-product sums, out_mac marks sums)
module gemv_simd_mul_pipe #(
  parameter int LANES      = 4,
  parameter int DIN0_WIDTH = 8,
  parameter int DIN1_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int NUM_STAGE  = 2
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*DIN0_WIDTH-1:0]  din0,
  input  logic [LANES*DIN1_WIDTH-1:0]  din1,
  input  logic                         in_sgn0,
  input  logic                         in_sgn1,
  input  logic                         in_mac,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*ACC_WIDTH-1:0]   dout,
  output logic                         out_mac
);
  localparam int W  = LANES*ACC_WIDTH;
  localparam int PW = DIN0_WIDTH+DIN1_WIDTH+2;
  logic adv;
  logic [W-1:0] p_in, f_p, acc, sum;
  logic f_v, f_mac, f_last;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DIN0_WIDTH:0] a;
    logic signed [DIN1_WIDTH:0] b;
    logic signed [PW-1:0] ax, bx, m;
    assign a  = {in_sgn0 & din0[l*DIN0_WIDTH+DIN0_WIDTH-1], din0[l*DIN0_WIDTH+:DIN0_WIDTH]};
    assign b  = {in_sgn1 & din1[l*DIN1_WIDTH+DIN1_WIDTH-1], din1[l*DIN1_WIDTH+:DIN1_WIDTH]};
    assign ax = PW'(a);
    assign bx = PW'(b);
    assign m  = ax * bx;
    assign p_in[l*ACC_WIDTH+:ACC_WIDTH] = ACC_WIDTH'(m);
    assign sum[l*ACC_WIDTH+:ACC_WIDTH]  = acc[l*ACC_WIDTH+:ACC_WIDTH] + f_p[l*ACC_WIDTH+:ACC_WIDTH];
  end
  if (NUM_STAGE < 1) begin : g_bad_stage
    $error("gemv_simd_mul_pipe: NUM_STAGE must be >= 1");
  end else if (NUM_STAGE == 1) begin : g_direct
    assign f_p    = p_in;
    assign f_v    = in_valid;
    assign f_mac  = in_mac;
    assign f_last = in_last;
  end else begin : g_pipe
    localparam int D = NUM_STAGE-1;
    logic [W-1:0] p_q [D];
    logic [D-1:0] v_q, mac_q, last_q;
    always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
        v_q    <= '0;
        mac_q  <= '0;
        last_q <= '0;
        for (int i = 0; i < D; i++) p_q[i] <= '0;
      end else if (adv) begin
        v_q    <= D'({v_q, in_valid});
        mac_q  <= D'({mac_q, in_mac});
        last_q <= D'({last_q, in_last});
        p_q[0] <= p_in;
        for (int i = 1; i < D; i++) p_q[i] <= p_q[i-1];
      end
    assign f_p    = p_q[D-1];
    assign f_v    = v_q[D-1];
    assign f_mac  = mac_q[D-1];
    assign f_last = last_q[D-1];
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      out_mac   <= 1'b0;
      dout      <= '0;
      acc       <= '0;
    end else if (adv) begin
      out_valid <= f_v && (!f_mac || f_last);
      if (f_v && !f_mac) begin
        dout    <= f_p;
        out_mac <= 1'b0;
      end
      if (f_v && f_mac) acc <= f_last ? '0 : sum;
      if (f_v && f_mac && f_last) begin
        dout    <= sum;
        out_mac <= 1'b1;
      end
    end
endmodule

// File: tb/tb_gemv_simd_mul_pipe.sv
// tb_gemv_simd_mul_pipe: directed checks of products, signedness, MAC rows, stalls and async reset
module tb_gemv_simd_mul_pipe;
  localparam int NS = 2;
  typedef struct packed {logic [95:0] d; logic m;} res_t;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0;
  logic in_valid = 1'b0, in_sgn0 = 1'b0, in_sgn1 = 1'b0, in_mac = 1'b0, in_last = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, out_mac;
  logic [31:0] din0 = '0, din1 = '0;
  logic [95:0] dout;
  int total = 0, passed = 0;
  res_t q[$];
  gemv_simd_mul_pipe #(.LANES(4), .DIN0_WIDTH(8), .DIN1_WIDTH(8), .ACC_WIDTH(24), .NUM_STAGE(NS)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .in_sgn0(in_sgn0), .in_sgn1(in_sgn1), .in_mac(in_mac),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_mac(out_mac)
  );
  always #5 ap_clk = ~ap_clk;
  always @(negedge ap_clk) if (ap_rst_n && out_valid && out_ready) q.push_back({dout, out_mac});
  function automatic logic [95:0] pk(input int d3, input int d2, input int d1, input int d0);
    return {24'(d3), 24'(d2), 24'(d1), 24'(d0)};
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask
  task automatic send(input logic mac, input logic last, input logic s0, input logic s1,
                      input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    in_valid = 1'b1; in_mac = mac; in_last = last; in_sgn0 = s0; in_sgn1 = s1; din0 = a; din1 = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge ap_clk);
      ok = in_ready;
      @(posedge ap_clk);
      #1;
    end
    total++;
    if (!ok) $display("FAIL send_accept: in_ready never seen high within 50 cycles");
    else passed++;
  endtask
  task automatic test_reset;
    #12;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else passed++;
    total++; if (dout !== '0) $display("FAIL rst_dout got %h exp 0", dout); else passed++;
    total++; if (out_mac !== 1'b0) $display("FAIL rst_out_mac got %b exp 0", out_mac); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else passed++;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    cyc(1);
  endtask
  task automatic test_mul_unsigned;
    logic [95:0] e;
    e = pk(17, 0, 6, 65025);
    q.delete();
    send(0, 0, 0, 0, {8'd17, 8'd0, 8'd2, 8'd255}, {8'd1, 8'd9, 8'd3, 8'd255});
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL mul_early_valid got %b exp 0", out_valid); else passed++;
    cyc(NS-1);
    total++; if (out_valid !== 1'b1) $display("FAIL mul_latency_valid got %b exp 1", out_valid); else passed++;
    total++; if (dout !== e) $display("FAIL mul_unsigned_dout got %h exp %h", dout, e); else passed++;
    total++; if (out_mac !== 1'b0) $display("FAIL mul_out_mac got %b exp 0", out_mac); else passed++;
    cyc(1);
    total++; if (out_valid !== 1'b0) $display("FAIL mul_single_beat got %b exp 0", out_valid); else passed++;
  endtask
  task automatic test_signed;
    logic [95:0] e[4];
    e = '{pk(0, 0, 0, -200), pk(0, 0, 0, 56), pk(0, 0, 0, 16384), pk(0, 0, 0, -14280)};
    q.delete();
    send(0, 0, 1, 0, 32'h0000_00FF, 32'd200);
    send(0, 0, 1, 1, 32'h0000_00FF, 32'd200);
    send(0, 1, 1, 1, 32'h0000_0080, 32'h0000_0080);
    send(0, 0, 0, 1, 32'h0000_00FF, 32'd200);
    in_valid = 1'b0;
    cyc(4);
    total++; if (q.size() != 4) $display("FAIL signed_count got %0d exp 4", q.size()); else passed++;
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      total++; if (q[i].d !== e[i] || q[i].m !== 1'b0)
        $display("FAIL signed_beat%0d got %h/%b exp %h/0", i, q[i].d, q[i].m, e[i]); else passed++;
    end
  endtask
  task automatic test_mac;
    q.delete();
    send(1, 0, 0, 0, {16'd0, 8'd1, 8'd3}, {16'd0, 8'd1, 8'd4});
    send(1, 0, 0, 0, {16'd0, 8'd2, 8'd5}, {16'd0, 8'd2, 8'd6});
    send(1, 1, 0, 0, {16'd0, 8'd3, 8'd7}, {16'd0, 8'd3, 8'd8});
    in_valid = 1'b0;
    cyc(4);
    total++; if (q.size() != 1) $display("FAIL mac_count got %0d exp 1", q.size()); else passed++;
    if (q.size() > 0) begin
      total++; if (q[0].d !== pk(0, 0, 14, 98)) $display("FAIL mac_sum got %h exp %h", q[0].d, pk(0, 0, 14, 98)); else passed++;
      total++; if (q[0].m !== 1'b1) $display("FAIL mac_out_mac got %b exp 1", q[0].m); else passed++;
    end
    q.delete();
    send(1, 1, 1, 1, 32'h0000_00FE, 32'd5);
    in_valid = 1'b0;
    cyc(4);
    total++; if (q.size() != 1) $display("FAIL mac_row2_count got %0d exp 1", q.size()); else passed++;
    if (q.size() > 0) begin
      total++; if (q[0].d !== pk(0, 0, 0, -10) || q[0].m !== 1'b1)
        $display("FAIL mac_row2 got %h/%b exp %h/1", q[0].d, q[0].m, pk(0, 0, 0, -10)); else passed++;
    end
  endtask
  task automatic test_back_to_back;
    logic [95:0] hold;
    q.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) send(0, 0, 0, 0, 32'(i+1), 32'(i+2));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge ap_clk);
        #1 out_ready = 1'b0;
        @(negedge ap_clk);
        hold = dout;
        repeat (5) begin
          @(negedge ap_clk);
          total++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || dout !== hold)
            $display("FAIL b2b_stall got rdy=%b vld=%b dout=%h exp rdy=0 vld=1 dout=%h", in_ready, out_valid, dout, hold);
          else passed++;
        end
        @(posedge ap_clk);
        #1 out_ready = 1'b1;
      end
    join
    cyc(6);
    total++; if (q.size() != 8) $display("FAIL b2b_count got %0d exp 8", q.size()); else passed++;
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      total++; if (q[i].d !== pk(0, 0, 0, (i+1)*(i+2)) || q[i].m !== 1'b0)
        $display("FAIL b2b_beat%0d got %h/%b exp %h/0", i, q[i].d, q[i].m, pk(0, 0, 0, (i+1)*(i+2))); else passed++;
    end
  endtask
  task automatic test_interleave;
    logic [95:0] e[3];
    logic em[3];
    e = '{pk(0, 0, 0, 100), pk(0, 0, 0, 49), pk(0, 0, 0, 62)};
    em = '{1'b0, 1'b0, 1'b1};
    q.delete();
    send(1, 0, 0, 0, 32'd2, 32'd3);
    send(0, 0, 0, 0, 32'd10, 32'd10);
    send(1, 0, 0, 0, 32'd4, 32'd5);
    send(0, 0, 0, 0, 32'd7, 32'd7);
    out_ready = 1'b0;
    send(1, 1, 0, 0, 32'd6, 32'd6);
    in_valid = 1'b0;
    cyc(5);
    total++; if (out_valid !== 1'b1 || dout !== pk(0, 0, 0, 49))
      $display("FAIL mix_stall_hold got %b/%h exp 1/%h", out_valid, dout, pk(0, 0, 0, 49)); else passed++;
    out_ready = 1'b1;
    cyc(4);
    total++; if (q.size() != 3) $display("FAIL mix_count got %0d exp 3", q.size()); else passed++;
    for (int i = 0; i < 3 && i < q.size(); i++) begin
      total++; if (q[i].d !== e[i] || q[i].m !== em[i])
        $display("FAIL mix_beat%0d got %h/%b exp %h/%b", i, q[i].d, q[i].m, e[i], em[i]); else passed++;
    end
  endtask
  task automatic test_async_reset;
    q.delete();
    out_ready = 1'b0;
    send(1, 0, 0, 0, 32'd5, 32'd5);
    send(0, 0, 0, 0, 32'd3, 32'd7);
    send(1, 0, 0, 0, 32'd5, 32'd5);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || dout !== pk(0, 0, 0, 21))
      $display("FAIL arst_pre got %b/%h exp 1/%h", out_valid, dout, pk(0, 0, 0, 21)); else passed++;
    #2 ap_rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || dout !== '0 || out_mac !== 1'b0)
      $display("FAIL arst_immediate got %b/%h/%b exp 0/0/0", out_valid, dout, out_mac); else passed++;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    out_ready = 1'b1;
    cyc(4);
    total++; if (q.size() != 0) $display("FAIL arst_discard got %0d exp 0", q.size()); else passed++;
    send(1, 1, 0, 0, 32'd3, 32'd3);
    in_valid = 1'b0;
    cyc(4);
    total++; if (q.size() != 1) $display("FAIL arst_row_count got %0d exp 1", q.size()); else passed++;
    if (q.size() > 0) begin
      total++; if (q[0].d !== pk(0, 0, 0, 9) || q[0].m !== 1'b1)
        $display("FAIL arst_row got %h/%b exp %h/1", q[0].d, q[0].m, pk(0, 0, 0, 9)); else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_mul_unsigned();
    test_signed();
    test_mac();
    test_back_to_back();
    test_interleave();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
